// File: rtl/rr_vc_arbiter_4x8_pkg.sv
// Shared definitions for the four-channel round-robin VC arbiter:
// FSM encoding, channel count and destination field width.
package rr_vc_arbiter_4x8_pkg;

    localparam int NUM_VC = 4;
    localparam int DEST_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        LOAD = 2'd2,
        HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/rr_grant_4.sv
// Combinational round-robin priority encoder: picks the first requester
// searching upward from last+1, wrapping modulo 4.
module rr_grant_4
    import rr_vc_arbiter_4x8_pkg::*;
(
    input  logic [NUM_VC-1:0] req,
    input  logic [1:0]        last,
    output logic [1:0]        gnt_idx,
    output logic              any_req
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_idx = '0;
        any_req = |req;
        idx     = '0;
        found   = 1'b0;
        // Offset 4 wraps back onto last itself, so it is searched last.
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                gnt_idx = idx;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_vc_arbiter_4x8.sv
// Pops one word at a time from four input FIFOs in round-robin order and
// routes it to the output FIFO named by its destination field.
module rr_vc_arbiter_4x8
    import rr_vc_arbiter_4x8_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int DEST_LSB  = 0,
    parameter int CNT_SIZE  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [NUM_VC-1:0]             fifo_empty,
    input  logic [NUM_VC*DATA_SIZE-1:0]   fifo_data,
    input  logic [NUM_VC-1:0]             dest_pause,
    output logic [NUM_VC-1:0]             pop,
    output logic [NUM_VC-1:0]             push,
    output logic [DATA_SIZE-1:0]          data_out,
    output logic [1:0]                    grant,
    output logic                          busy,
    output logic                          arb_error,
    output logic [CNT_SIZE-1:0]           fwd_count,
    output logic [1:0]                    state_dbg
);

    // Handshake: pop[i] reads FIFO i and its data is sampled one cycle later;
    // push[d] writes data_out into output FIFO d only while dest_pause[d] is low.

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [1:0]            last_q, last_d;
    logic [DATA_SIZE-1:0]  hold_q, hold_d;
    logic [DATA_SIZE-1:0]  dout_q, dout_d;
    logic [CNT_SIZE-1:0]   cnt_q, cnt_d;

    logic [1:0]            rr_idx;
    logic                  rr_any;
    logic [DEST_W-1:0]     dest;
    logic [DATA_SIZE-1:0]  fifo_word;

    rr_grant_4 u_rr_grant (
        .req     (~fifo_empty),
        .last    (last_q),
        .gnt_idx (rr_idx),
        .any_req (rr_any)
    );

    assign dest = hold_q[DEST_LSB +: DEST_W];

    always_comb begin
        fifo_word = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (grant_q == 2'(i)) begin
                fifo_word = fifo_data[i*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        hold_d    = hold_q;
        dout_d    = dout_q;
        cnt_d     = cnt_q;
        pop       = '0;
        push      = '0;
        arb_error = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && rr_any) begin
                    grant_d = rr_idx;
                    state_d = POP;
                end
            end
            POP: begin
                // The flag may have dropped since arbitration; retry later
                // without advancing the round-robin pointer.
                if (!fifo_empty[grant_q]) begin
                    pop[grant_q] = 1'b1;
                    state_d      = LOAD;
                end else begin
                    arb_error = 1'b1;
                    state_d   = IDLE;
                end
            end
            LOAD: begin
                hold_d  = fifo_word;
                state_d = HOLD;
            end
            HOLD: begin
                if (!dest_pause[dest]) begin
                    push[dest] = 1'b1;
                    dout_d     = hold_q;
                    cnt_d      = cnt_q + CNT_SIZE'(1);
                    last_d     = grant_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 2'd3;
            hold_q  <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    // The word must be on the bus during its push cycle, and the register
    // keeps showing it afterwards until the next push.
    assign data_out  = (|push) ? hold_q : dout_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign fwd_count = cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_rr_vc_arbiter_4x8.sv
// Directed bench for rr_vc_arbiter_4x8: a per-cycle vector table plus
// hand-written sequences for fairness, stall, reset-in-HOLD and enable.
module tb_rr_vc_arbiter_4x8;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  fifo_empty;
    logic [31:0] fifo_data;
    logic [3:0]  dest_pause;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [7:0]  data_out;
    logic [1:0]  grant;
    logic        busy;
    logic        arb_error;
    logic [15:0] fwd_count;
    logic [1:0]  state_dbg;

    int n_cmp;
    int n_bad;

    rr_vc_arbiter_4x8 #(.DATA_SIZE(8), .DEST_LSB(0), .CNT_SIZE(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .dest_pause (dest_pause),
        .pop        (pop),
        .push       (push),
        .data_out   (data_out),
        .grant      (grant),
        .busy       (busy),
        .arb_error  (arb_error),
        .fwd_count  (fwd_count),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  empty;
        logic [31:0] data;
        logic [3:0]  pause;
        logic [3:0]  e_pop;
        logic [3:0]  e_push;
        logic [7:0]  e_dout;
        logic [1:0]  e_grant;
        logic        e_busy;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [3:0] empty, input logic [31:0] data,
                         input logic [3:0] pause);
        @(negedge clk);
        enable     = en;
        fifo_empty = empty;
        fifo_data  = data;
        dest_pause = pause;
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_pop, input logic [3:0] e_push,
                           input logic [7:0] e_dout, input logic [1:0] e_grant,
                           input logic e_busy, input logic e_err, input logic [15:0] e_cnt);
        chk({tag, " pop"},   pop,       e_pop);
        chk({tag, " push"},  push,      e_push);
        chk({tag, " dout"},  data_out,  e_dout);
        chk({tag, " grant"}, grant,     e_grant);
        chk({tag, " busy"},  busy,      e_busy);
        chk({tag, " err"},   arb_error, e_err);
        chk({tag, " cnt"},   fwd_count, e_cnt);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset      = 1'b1;
        enable     = 1'b0;
        fifo_empty = 4'b1111;
        fifo_data  = '0;
        dest_pause = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all(tag, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0, 16'd0);
    endtask

    initial begin
        logic [7:0] b [4];
        logic [3:0] e_pop;
        logic [3:0] e_push;
        int k;
        int ph;

        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        enable     = 1'b0;
        fifo_empty = 4'b1111;
        fifo_data  = '0;
        dest_pause = 4'b0000;

        // Single word from FIFO 2, then an empty-in-POP retry of FIFO 0.
        vecs[0]  = '{1'b1, 4'b1011, 32'h00A1_0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 4'b1011, 32'h00A1_0000, 4'b0000, 4'b0100, 4'b0000, 8'h00, 2'd2, 1'b1, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 4'b1111, 32'h00A1_0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd2, 1'b1, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 4'b1111, 32'h00A1_0000, 4'b0000, 4'b0000, 4'b0010, 8'hA1, 2'd2, 1'b1, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 4'b1111, 32'h00A1_0000, 4'b0000, 4'b0000, 4'b0000, 8'hA1, 2'd2, 1'b0, 1'b0, 16'd1};
        vecs[5]  = '{1'b1, 4'b1110, 32'h0000_005E, 4'b0000, 4'b0000, 4'b0000, 8'hA1, 2'd2, 1'b0, 1'b0, 16'd1};
        vecs[6]  = '{1'b1, 4'b1111, 32'h0000_005E, 4'b0000, 4'b0000, 4'b0000, 8'hA1, 2'd0, 1'b1, 1'b1, 16'd1};
        vecs[7]  = '{1'b1, 4'b1100, 32'h0000_005E, 4'b0000, 4'b0000, 4'b0000, 8'hA1, 2'd0, 1'b0, 1'b0, 16'd1};
        vecs[8]  = '{1'b1, 4'b1100, 32'h0000_005E, 4'b0000, 4'b0001, 4'b0000, 8'hA1, 2'd0, 1'b1, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 4'b1101, 32'h0000_005E, 4'b0000, 4'b0000, 4'b0000, 8'hA1, 2'd0, 1'b1, 1'b0, 16'd1};
        vecs[10] = '{1'b1, 4'b1101, 32'h0000_005E, 4'b0000, 4'b0000, 4'b0100, 8'h5E, 2'd0, 1'b1, 1'b0, 16'd1};
        vecs[11] = '{1'b0, 4'b1101, 32'h0000_005E, 4'b0000, 4'b0000, 4'b0000, 8'h5E, 2'd0, 1'b0, 1'b0, 16'd2};
        vecs[12] = '{1'b0, 4'b1101, 32'h0000_005E, 4'b0000, 4'b0000, 4'b0000, 8'h5E, 2'd0, 1'b0, 1'b0, 16'd2};

        do_reset("reset0");
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].en, vecs[i].empty, vecs[i].data, vecs[i].pause);
            chk_all($sformatf("row%0d", i), vecs[i].e_pop, vecs[i].e_push, vecs[i].e_dout,
                    vecs[i].e_grant, vecs[i].e_busy, vecs[i].e_err, vecs[i].e_cnt);
        end

        // Fairness: all inputs non-empty, grants 0,1,2,3,0 at 4 cycles per word.
        do_reset("reset1");
        b[0] = 8'h40;
        b[1] = 8'h31;
        b[2] = 8'h22;
        b[3] = 8'h13;
        for (int c = 0; c < 20; c++) begin
            drive(1'b1, 4'b0000, {b[3], b[2], b[1], b[0]}, 4'b0000);
            ph     = c % 4;
            k      = (c / 4) % 4;
            e_pop  = (ph == 1) ? (4'b0001 << k) : 4'b0000;
            e_push = (ph == 3) ? (4'b0001 << b[k][1:0]) : 4'b0000;
            chk($sformatf("rr c%0d pop", c), pop, e_pop);
            chk($sformatf("rr c%0d push", c), push, e_push);
            chk($sformatf("rr c%0d state", c), state_dbg, 32'(ph));
            if (ph == 1) chk($sformatf("rr c%0d grant", c), grant, 32'(k));
            if (ph == 3) chk($sformatf("rr c%0d dout", c), data_out, b[k]);
        end
        drive(1'b0, 4'b1111, '0, 4'b0000);
        chk("rr count", fwd_count, 16'd5);

        // Stall on dest 3 for 10 cycles with enable dropped while busy.
        do_reset("reset2");
        drive(1'b1, 4'b1101, 32'h0000_0300, 4'b0000);
        chk("stall idle busy", busy, 1'b0);
        drive(1'b1, 4'b1101, 32'h0000_0300, 4'b0000);
        chk("stall pop", pop, 4'b0010);
        chk("stall grant", grant, 2'd1);
        drive(1'b0, 4'b1101, 32'h0000_0300, 4'b0000);
        chk("stall load pop", pop, 4'b0000);
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 4'b1101, 32'h0000_0300, 4'b1000);
            chk($sformatf("stall%0d push", c), push, 4'b0000);
            chk($sformatf("stall%0d pop", c), pop, 4'b0000);
            chk($sformatf("stall%0d busy", c), busy, 1'b1);
            chk($sformatf("stall%0d dout", c), data_out, 8'h00);
        end
        drive(1'b0, 4'b1101, 32'h0000_0300, 4'b0000);
        chk("release push", push, 4'b1000);
        chk("release dout", data_out, 8'h03);
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 4'b1101, 32'h0000_0300, 4'b0000);
            chk_all($sformatf("after%0d", c), 4'b0000, 4'b0000, 8'h03, 2'd1, 1'b0, 1'b0, 16'd1);
        end

        // Reset while a word (8'h55, dest 1) sits in HOLD.
        do_reset("reset3");
        drive(1'b1, 4'b1110, 32'h0000_0055, 4'b0010);
        drive(1'b1, 4'b1110, 32'h0000_0055, 4'b0010);
        chk("rh pop", pop, 4'b0001);
        drive(1'b1, 4'b1111, 32'h0000_0055, 4'b0010);
        drive(1'b1, 4'b1111, 32'h0000_0055, 4'b0010);
        chk("rh hold busy", busy, 1'b1);
        chk("rh hold push", push, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rh in-reset push", push, 4'b0000);
        drive(1'b1, 4'b1111, 32'h0000_0055, 4'b0000);
        reset = 1'b0;
        #1;
        chk_all("rh cleared", 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0, 16'd0);
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 4'b1111, 32'h0000_0055, 4'b0000);
            chk_all($sformatf("rh idle%0d", c), 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0, 1'b0, 16'd0);
        end

        // Enable low with every FIFO non-empty, then raised.
        do_reset("reset4");
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b0000, 32'h1322_3140, 4'b0000);
            chk($sformatf("en-off%0d pop", c), pop, 4'b0000);
            chk($sformatf("en-off%0d busy", c), busy, 1'b0);
        end
        drive(1'b1, 4'b0000, 32'h1322_3140, 4'b0000);
        chk("en-rise pop", pop, 4'b0000);
        drive(1'b1, 4'b0000, 32'h1322_3140, 4'b0000);
        chk("en-on pop", pop, 4'b0001);
        chk("en-on grant", grant, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
